// File: rtl/toy_bus_fabric.sv
// Registered, handshaken bus fabric: decodes CPU word addresses into RAM, peripheral
// slots and an internal error block, with wait states, ack timeout and fault capture.
module toy_bus_fabric #(
  parameter int              NUM_SLOTS   = 4,
  parameter int              SLOT_BITS   = 4,
  parameter logic [15:0]     PERIPH_BASE = 16'h0400,
  parameter int              RAM_WORDS   = 1024,
  parameter logic [15:0]     ERR_BASE    = 16'h04F0,
  parameter logic [7:0]      ACK_MASK    = 8'h00,
  parameter int              WAIT_STATES = 0,
  parameter int              TIMEOUT     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_req,
  input  logic                   i_we,
  input  logic [15:0]            i_addr,
  input  logic [15:0]            i_wdata,
  output logic [15:0]            o_rdata,
  output logic                   o_ready,
  output logic                   o_ram_sel,
  input  logic [15:0]            i_ram_rdata,
  output logic [NUM_SLOTS-1:0]   o_sel,
  output logic                   o_we,
  output logic [15:0]            o_addr,
  output logic [15:0]            o_wdata,
  input  logic [16*NUM_SLOTS-1:0] i_rdata,
  input  logic [NUM_SLOTS-1:0]   i_ack,
  output logic                   o_err_int
);

  localparam int MAXC = (WAIT_STATES > TIMEOUT) ? WAIT_STATES : TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int SW   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [16:0]   RAM_LIM = 17'(RAM_WORDS);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WS_LAST = CW'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {T_RAM, T_SLOT, T_ERR, T_UNMAP} tgt_t;

  state_t state, nxt;
  tgt_t   tgt, dec;
  logic [SW-1:0] slot;
  logic [CW-1:0] cnt;
  logic [1:0]    status;
  logic [15:0]   fault_addr;
  logic [15:0]   off, sidx;
  logic          leave, tmo;
  logic [NUM_SLOTS-1:0][15:0] slot_data;

  assign slot_data = i_rdata;
  assign off       = i_addr - PERIPH_BASE;
  assign sidx      = off >> SLOT_BITS;

  always_comb begin
    dec = T_UNMAP;
    if ({1'b0, i_addr} < RAM_LIM)                              dec = T_RAM;
    else if (sidx < 16'(NUM_SLOTS))                            dec = T_SLOT;
    else if (i_addr == ERR_BASE || i_addr == ERR_BASE + 16'd1) dec = T_ERR;
  end

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= IDLE;
    else         state <= nxt;

  // Ack is checked before the timeout so a same-cycle ack completes cleanly.
  always_comb begin
    nxt   = state;
    leave = 1'b0;
    tmo   = 1'b0;
    case (state)
      IDLE:   if (i_req) nxt = (dec == T_RAM || dec == T_SLOT) ? ACCESS : RESP;
      ACCESS: begin
        if (tgt == T_RAM) leave = 1'b1;
        else if (ACK_MASK[slot]) begin
          if (i_ack[slot])         leave = 1'b1;
          else if (cnt == TO_LAST) begin leave = 1'b1; tmo = 1'b1; end
        end
        else if (cnt == WS_LAST)   leave = 1'b1;
        if (leave) nxt = RESP;
      end
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Selects decode from state so an async reset drops them immediately.
  always_comb begin
    o_sel = '0;
    if (state == ACCESS && tgt == T_SLOT) o_sel[slot] = 1'b1;
    o_ram_sel = (state == ACCESS) && (tgt == T_RAM);
    o_ready   = (state == RESP);
    o_err_int = |status;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tgt        <= T_RAM;
      slot       <= '0;
      cnt        <= '0;
      o_we       <= 1'b0;
      o_addr     <= '0;
      o_wdata    <= '0;
      o_rdata    <= '0;
      status     <= '0;
      fault_addr <= '0;
    end else begin
      case (state)
        IDLE: if (i_req) begin
          o_addr  <= i_addr;
          o_we    <= i_we;
          o_wdata <= i_wdata;
          tgt     <= dec;
          slot    <= sidx[SW-1:0];
          cnt     <= '0;
          if (dec == T_ERR) begin
            o_rdata <= i_addr[0] ? {14'd0, status} : fault_addr;
            if (i_we && i_addr[0]) status <= '0;
          end else if (dec == T_UNMAP) begin
            o_rdata <= '0;
            if (status == 2'b00) fault_addr <= i_addr;
            status[0] <= 1'b1;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (leave) begin
            if (tmo) begin
              o_rdata <= '0;
              if (status == 2'b00) fault_addr <= o_addr;
              status[1] <= 1'b1;
            end else begin
              o_rdata <= (tgt == T_RAM) ? i_ram_rdata : slot_data[slot];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/toy_bus_fabric.md
# toy_bus_fabric

Parametrised bus fabric between the toy CPU and its memory and peripherals. It replaces the fixed combinational read mux with a registered, handshaken transaction engine. It decodes a 16-bit word address into RAM, NUM_SLOTS equal-sized peripheral slots and a 2-word internal error block. It adds per-slot wait states or ack handshakes, an ack timeout, and unmapped/timeout fault capture with an interrupt.

## Interface
- NUM_SLOTS, 4: number of peripheral slots (1..8).
- SLOT_BITS, 4: each slot spans 2^SLOT_BITS words.
- PERIPH_BASE, 16'h0400: base address of slot 0; slot k base = PERIPH_BASE + k*2^SLOT_BITS.
- RAM_WORDS, 1024: RAM occupies 0..RAM_WORDS-1.
- ERR_BASE, 16'h04F0: error block; +0 fault address, +1 status.
- ACK_MASK, 0: bit k=1 means slot k completes on i_ack[k]; bit k=0 means it completes after WAIT_STATES cycles.
- WAIT_STATES, 0: extra ACCESS cycles for non-ack slots (0..15).
- TIMEOUT, 16: ACCESS cycles allowed for an ack slot before abort (>=1).
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_req  in  1  CPU request; held until o_ready.
- i_we  in  1  1 = write.
- i_addr  in  16  word address.
- i_wdata  in  16  write data.
- o_rdata  out  16  read data, valid while o_ready.
- o_ready  out  1  one-cycle completion pulse.
- o_ram_sel  out  1  RAM select.
- i_ram_rdata  in  16  RAM synchronous read data.
- o_sel  out  NUM_SLOTS  one-hot slot select.
- o_we, o_addr[15:0], o_wdata[15:0]  out  latched transaction attributes, shared by RAM and slots.
- i_rdata  in  16*NUM_SLOTS  slot k data in bits [16k+15:16k].
- i_ack  in  NUM_SLOTS  slot completion.
- o_err_int  out  1  level; high while any status bit is set.

## Operation
- Reset values: FSM IDLE; all outputs 0; fault address 0; status 0; counters 0.
- FSM states:
  - IDLE: when i_req is sampled high, latch i_addr/i_we/i_wdata and decode in priority order: RAM, slot, error block, unmapped.
    - RAM or slot: go to ACCESS.
    - Error block or unmapped: go to RESP.
  - ACCESS: assert the selected o_ram_sel or o_sel[k], with o_we/o_addr/o_wdata held stable.
    - RAM: exactly 1 cycle.
    - Non-ack slot: 1+WAIT_STATES cycles.
    - Ack slot: lasts until i_ack[k] is high, or until the TIMEOUT-th ACCESS cycle passes without ack.
    - On leaving ACCESS, register the selected read data into o_rdata and go to RESP.
  - RESP: o_ready=1 for exactly one cycle, all selects 0, then IDLE.
- Ack and timeout landing in the same cycle: ack wins; no error is recorded.
- Timeout abort: o_rdata=0; set status bit 1.
- Unmapped access: o_rdata=0; set status bit 0; writes are discarded.
- Error block:
  - Read +0 returns the fault address.
  - Read +1 returns {14'd0, timeout, unmapped}.
  - Writing any value to +1 clears the status. The fault address is retained.
  - Writes to +0 are ignored.
- Fault address is sticky: it is written only when status is 0 at the moment of the fault. Later faults only OR into the status bits.
- i_req changes after it is sampled are ignored until the transaction completes. A held i_req after RESP starts a new transaction.
- Reset mid-transaction: return to IDLE immediately; selects drop asynchronously; no o_ready.
- i_ack on an unselected slot is ignored.

## Timing
- Request sampled in IDLE at cycle 0. Ready cycles:
  - Error block or unmapped: o_ready at cycle 1.
  - RAM: select at cycle 1, o_ready at cycle 2 carrying i_ram_rdata from cycle 1.
  - Non-ack slot: select cycles 1..1+WAIT_STATES, o_ready at 2+WAIT_STATES.
  - Ack slot with ack at cycle n: o_ready at n+1.
  - Ack slot timing out: o_ready at TIMEOUT+1.
- Minimum spacing between back-to-back transactions: IDLE re-samples at cycle RESP+1.
- Counter width is $clog2(max(WAIT_STATES,TIMEOUT)+1). Address arithmetic is 16-bit. Slot index = (addr-PERIPH_BASE)>>SLOT_BITS, valid only if < NUM_SLOTS.
- o_err_int rises in the RESP cycle of the faulting access. It falls in the RESP cycle of the clearing write.

## Test plan
- RAM read at 16'h0010, i_ram_rdata=16'hBEEF: o_ram_sel high at cycle 1 only; o_ready with o_rdata=16'hBEEF at cycle 2.
- WAIT_STATES=2, ACK_MASK=0, write 16'h1234 to 16'h0412: o_sel=4'b0010 for cycles 1..3 with o_wdata=16'h1234 and o_we=1; o_ready at cycle 4.
- ACK_MASK=4'b0100, read 16'h0425 with ack at cycle 5 and data 16'h00A5: o_ready at cycle 6 with 16'h00A5.
- TIMEOUT=16 with ack never asserted: o_sel drops after cycle 16; o_ready at cycle 17 with 0; status=2; o_err_int=1; fault address=16'h0425. Repeat with ack exactly at cycle 16: no error.
- Read unmapped 16'h8000, then 16'h9000: status=1, fault address stays 16'h8000. Write 16'h04F1: o_err_int falls in the RESP cycle of that write. Reading 16'h04F0 still returns 16'h8000.
- Assert i_reset at cycle 2 of a waiting slot access: o_sel=0 immediately, no o_ready. After release, a new RAM read completes normally.
